mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage that sits directly downstream of the execute stage.
- Consumes the EX/MEM register contents: pc, ALU result, store data and memory control.
- Issues a load or store to the data-memory port with a valid/ready request and response handshake, then sign- or zero-extends load data.
- Drives the MEM/WB register and raises a stall to upstream stages while an access is outstanding.

Parameters:
WIDTH, 32, datapath width; must be 32.
ADDR_LEN, 32, address and pc width.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
valid_i  in  1  EX/MEM holds a valid instruction
pc_i  in  ADDR_LEN  pc from EX/MEM
alu_in  in  WIDTH  ALU result; used as the byte address for memory ops
store_data  in  WIDTH  rs2 value for stores
mem_read  in  1  instruction is a load
mem_write  in  1  instruction is a store
mem_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal
mem_unsigned  in  1  zero-extend load data (LBU/LHU)
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts the request
dmem_addr  out  ADDR_LEN  word-aligned address, {addr[ADDR_LEN-1:2],2'b00}
dmem_we  out  1  request is a write
dmem_wdata  out  WIDTH  store data replicated across byte lanes
dmem_wstrb  out  4  byte enables
dmem_rsp_valid  in  1  read data valid
dmem_rdata  in  WIDTH  read word
stall_o  out  1  upstream must hold its state
valid_o  out  1  MEM/WB valid
pc_o  out  ADDR_LEN  MEM/WB pc
wb_data  out  WIDTH  MEM/WB result: load data or passed-through ALU result
misalign_o  out  1  MEM/WB misaligned/illegal-access flag

Behaviour:
- Reset (async): state=IDLE; valid_o, pc_o, wb_data, misalign_o, dmem_req_valid, dmem_we, dmem_wstrb all 0. Reset mid-access abandons the request; dmem_req_valid drops immediately.
- A memory op is valid_i & (mem_read | mem_write). If both mem_read and mem_write are high, the instruction is treated as a load.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or mem_size=11.
- FSM states: IDLE, REQ, WAIT.
- IDLE, non-memory op:
  - 1-cycle latency: next edge valid_o=valid_i, pc_o=pc_i, wb_data=alu_in, misalign_o=0.
  - No stall.
- IDLE, misaligned memory op:
  - No dmem request.
  - Next edge valid_o=1, misalign_o=1, pc_o=pc_i, wb_data=alu_in.
  - No stall.
- IDLE, aligned memory op:
  - Latch pc, address, size, unsigned, we, wdata and wstrb.
  - Next edge valid_o=0; go to REQ.
  - stall_o=1 combinationally in that cycle.
- REQ:
  - dmem_req_valid=1 with the latched fields, held stable until accepted.
  - On dmem_req_ready, a store goes to IDLE and writes MEM/WB next edge: valid_o=1, wb_data=latched address.
  - On dmem_req_ready, a load goes to WAIT with valid_o=0.
  - No ready: stay in REQ.
  - stall_o=1.
- WAIT:
  - dmem_req_valid=0.
  - On dmem_rsp_valid: select the lane by addr[1:0] (half uses addr[1]), then sign- or zero-extend. Next edge valid_o=1, wb_data=extended value, go to IDLE.
  - stall_o=1 in WAIT, including the response cycle; it drops in the cycle after.
- stall_o = (state!=IDLE) | (state==IDLE & aligned memory op).
- Stores:
  - byte: wdata={4{sd[7:0]}}, wstrb=0001<<addr[1:0]
  - half: wdata={2{sd[15:0]}}, wstrb=0011<<addr[1:0]
  - word: wdata=sd, wstrb=1111
- Loads: dmem_we=0, wstrb=0000.
- dmem_rsp_valid outside WAIT is ignored. dmem_req_ready outside REQ is ignored.
- While stall_o=1, inputs are not sampled.
- Bubbles (valid_i=0) produce valid_o=0 and never touch memory.

Test Plan:
- ALU pass-through: valid_i=1, no mem op, pc_i=0x100, alu_in=0xDEADBEEF -> next cycle valid_o=1, pc_o=0x100, wb_data=0xDEADBEEF; stall_o stays 0.
- Byte store with 2-cycle ready delay: alu_in=0x1003, size=00, store_data=0x000000A5 -> dmem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5, valid held 3 cycles; valid_o=1 the cycle after acceptance.
- Signed half load: addr=0x2002, rdata=0x8001_1234, response 3 cycles after accept -> wb_data=0xFFFF8001. Same with mem_unsigned=1 -> 0x00008001. stall_o high from capture until the response cycle inclusive.
- Misaligned word load: addr=0x3001, size=10 -> no dmem_req_valid; next cycle valid_o=1, misalign_o=1, no stall.
- Async reset asserted while in WAIT -> dmem_req_valid=0, valid_o=0, state IDLE immediately. A subsequent stray dmem_rsp_valid produces no valid_o.
- Back-to-back load then ALU op: the ALU op is held upstream by stall_o and emerges on valid_o the cycle after the load result, with no duplication or loss.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: takes EX/MEM contents, performs a load or store
// over a valid/ready data-memory port, and drives the MEM/WB register.
module mem_stage #(
  parameter int WIDTH    = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic [WIDTH-1:0]    alu_in,
  input  logic [WIDTH-1:0]    store_data,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [1:0]          mem_size,
  input  logic                mem_unsigned,
  output logic                dmem_req_valid,
  input  logic                dmem_req_ready,
  output logic [ADDR_LEN-1:0] dmem_addr,
  output logic                dmem_we,
  output logic [WIDTH-1:0]    dmem_wdata,
  output logic [3:0]          dmem_wstrb,
  input  logic                dmem_rsp_valid,
  input  logic [WIDTH-1:0]    dmem_rdata,
  output logic                stall_o,
  output logic                valid_o,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic [WIDTH-1:0]    wb_data,
  output logic                misalign_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_LEN-1:0] r_pc;
  logic [WIDTH-1:0]    r_addr;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic                r_we;
  logic [WIDTH-1:0]    r_wdata;
  logic [3:0]          r_wstrb;

  logic                r_valid_o;
  logic [ADDR_LEN-1:0] r_pc_o;
  logic [WIDTH-1:0]    r_wb_data;
  logic                r_misalign;

  logic             w_mem_op;
  logic             w_is_store;
  logic             w_misalign;
  logic             w_start;
  logic [WIDTH-1:0] w_wdata;
  logic [3:0]       w_wstrb;
  logic [WIDTH-1:0] w_load_ext;

  // A simultaneous read+write request is treated as a load.
  assign w_mem_op   = valid_i & (mem_read | mem_write);
  assign w_is_store = mem_write & ~mem_read;
  assign w_misalign = (mem_size == 2'b11) |
                      ((mem_size == 2'b01) & alu_in[0]) |
                      ((mem_size == 2'b10) & (alu_in[1:0] != 2'b00));
  assign w_start    = (r_state == S_IDLE) & w_mem_op & ~w_misalign;

  always_comb begin
    w_wdata = store_data;
    w_wstrb = 4'b1111;
    case (mem_size)
      2'b00: begin
        w_wdata = {4{store_data[7:0]}};
        w_wstrb = 4'b0001 << alu_in[1:0];
      end
      2'b01: begin
        w_wdata = {2{store_data[15:0]}};
        w_wstrb = 4'b0011 << alu_in[1:0];
      end
      default: ;
    endcase
    if (!w_is_store) w_wstrb = 4'b0000;
  end

  // Lane select from the latched byte offset, then sign/zero extension.
  always_comb begin
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    case (r_addr[1:0])
      2'b00:   v_byte = dmem_rdata[7:0];
      2'b01:   v_byte = dmem_rdata[15:8];
      2'b10:   v_byte = dmem_rdata[23:16];
      default: v_byte = dmem_rdata[31:24];
    endcase
    v_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_size)
      2'b00:   w_load_ext = {{(WIDTH-8){v_byte[7] & ~r_unsigned}}, v_byte};
      2'b01:   w_load_ext = {{(WIDTH-16){v_half[15] & ~r_unsigned}}, v_half};
      default: w_load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_next = S_REQ;
      S_REQ:  if (dmem_req_ready) w_state_next = r_we ? S_IDLE : S_WAIT;
      S_WAIT: if (dmem_rsp_valid) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_req_valid = (r_state == S_REQ);
    stall_o        = (r_state != S_IDLE) | w_start;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= '0;
      r_addr     <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else if (w_start) begin
      r_pc       <= pc_i;
      r_addr     <= alu_in;
      r_size     <= mem_size;
      r_unsigned <= mem_unsigned;
      r_we       <= w_is_store;
      r_wdata    <= w_wdata;
      r_wstrb    <= w_wstrb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_o  <= 1'b0;
      r_pc_o     <= '0;
      r_wb_data  <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_valid_o  <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: if (!w_start) begin
          r_valid_o  <= valid_i;
          r_pc_o     <= pc_i;
          r_wb_data  <= alu_in;
          r_misalign <= w_mem_op & w_misalign;
        end
        S_REQ: if (dmem_req_ready && r_we) begin
          r_valid_o <= 1'b1;
          r_pc_o    <= r_pc;
          r_wb_data <= r_addr;
        end
        S_WAIT: if (dmem_rsp_valid) begin
          r_valid_o <= 1'b1;
          r_pc_o    <= r_pc;
          r_wb_data <= w_load_ext;
        end
        default: ;
      endcase
    end
  end

  assign dmem_addr  = {r_addr[ADDR_LEN-1:2], 2'b00};
  assign dmem_we    = r_we;
  assign dmem_wdata = r_wdata;
  assign dmem_wstrb = r_wstrb;
  assign valid_o    = r_valid_o;
  assign pc_o       = r_pc_o;
  assign wb_data    = r_wb_data;
  assign misalign_o = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: pass-through, stores, loads,
// misalignment, async reset mid-access and load/ALU back-to-back ordering.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [31:0] pc_i;
  logic [31:0] alu_in;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] wb_data;
  logic        misalign_o;

  int checks = 0;
  int failures = 0;

  mem_stage #(.WIDTH(32), .ADDR_LEN(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .pc_i(pc_i), .alu_in(alu_in),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata), .stall_o(stall_o), .valid_o(valid_o),
    .pc_o(pc_o), .wb_data(wb_data), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic un, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] sd);
    valid_i = v; mem_read = rd; mem_write = wr; mem_size = sz;
    mem_unsigned = un; pc_i = pc; alu_in = a; store_data = sd;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = 32'h0;
    #12;
    chk("rst_valid_o", {31'b0, valid_o}, 32'h0);
    chk("rst_req_valid", {31'b0, dmem_req_valid}, 32'h0);
    chk("rst_wstrb", {28'b0, dmem_wstrb}, 32'h0);
    chk("rst_we", {31'b0, dmem_we}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_misalign", {31'b0, misalign_o}, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    @(negedge clk); reset = 1'b0;
    cyc();

    // ALU pass-through
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0);
    #1 chk("alu_stall", {31'b0, stall_o}, 32'h0);
    cyc();
    chk("alu_valid_o", {31'b0, valid_o}, 32'h1);
    chk("alu_pc_o", pc_o, 32'h100);
    chk("alu_wb", wb_data, 32'hDEADBEEF);
    valid_i = 1'b0;
    cyc();
    chk("bubble_valid_o", {31'b0, valid_o}, 32'h0);

    // Byte store, ready after two waiting cycles
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h104, 32'h1003, 32'h000000A5);
    #1 chk("sb_capture_stall", {31'b0, stall_o}, 32'h1);
    chk("sb_capture_noreq", {31'b0, dmem_req_valid}, 32'h0);
    cyc();
    valid_i = 1'b0;
    chk("sb_req1", {31'b0, dmem_req_valid}, 32'h1);
    chk("sb_addr", dmem_addr, 32'h1000);
    chk("sb_wstrb", {28'b0, dmem_wstrb}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("sb_we", {31'b0, dmem_we}, 32'h1);
    chk("sb_valid_o_req", {31'b0, valid_o}, 32'h0);
    cyc();
    chk("sb_req2", {31'b0, dmem_req_valid}, 32'h1);
    chk("sb_stall2", {31'b0, stall_o}, 32'h1);
    cyc();
    chk("sb_req3", {31'b0, dmem_req_valid}, 32'h1);
    dmem_req_ready = 1'b1;
    cyc();
    dmem_req_ready = 1'b0;
    chk("sb_done_valid_o", {31'b0, valid_o}, 32'h1);
    chk("sb_done_wb", wb_data, 32'h1003);
    chk("sb_done_pc", pc_o, 32'h104);
    chk("sb_done_req", {31'b0, dmem_req_valid}, 32'h0);
    chk("sb_done_stall", {31'b0, stall_o}, 32'h0);

    // Half store at offset 2, immediate ready
    drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h108, 32'h1102, 32'h1234BEEF);
    cyc();
    valid_i = 1'b0;
    chk("sh_wstrb", {28'b0, dmem_wstrb}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    dmem_req_ready = 1'b1;
    cyc();
    dmem_req_ready = 1'b0;
    chk("sh_done_valid_o", {31'b0, valid_o}, 32'h1);

    // Signed half load, response on the third WAIT cycle
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h200, 32'h2002, 32'h0);
    #1 chk("lh_capture_stall", {31'b0, stall_o}, 32'h1);
    cyc();
    valid_i = 1'b0;
    chk("lh_addr", dmem_addr, 32'h2000);
    chk("lh_we", {31'b0, dmem_we}, 32'h0);
    chk("lh_wstrb", {28'b0, dmem_wstrb}, 32'h0);
    dmem_req_ready = 1'b1;
    cyc();
    dmem_req_ready = 1'b0;
    chk("lh_wait_req", {31'b0, dmem_req_valid}, 32'h0);
    chk("lh_wait_stall", {31'b0, stall_o}, 32'h1);
    chk("lh_wait_valid_o", {31'b0, valid_o}, 32'h0);
    cyc();
    cyc();
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h80011234;
    #1 chk("lh_rsp_stall", {31'b0, stall_o}, 32'h1);
    cyc();
    dmem_rsp_valid = 1'b0;
    chk("lh_valid_o", {31'b0, valid_o}, 32'h1);
    chk("lh_wb", wb_data, 32'hFFFF8001);
    chk("lh_pc", pc_o, 32'h200);
    chk("lh_after_stall", {31'b0, stall_o}, 32'h0);

    // Unsigned half load, same address and data
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h204, 32'h2002, 32'h0);
    cyc();
    valid_i = 1'b0; dmem_req_ready = 1'b1;
    cyc();
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1;
    cyc();
    dmem_rsp_valid = 1'b0;
    chk("lhu_wb", wb_data, 32'h00008001);

    // Signed byte load from lane 1
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h208, 32'h4001, 32'h0);
    cyc();
    valid_i = 1'b0; dmem_req_ready = 1'b1;
    cyc();
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'h123480FF;
    cyc();
    dmem_rsp_valid = 1'b0;
    chk("lb_wb", wb_data, 32'hFFFFFF80);

    // Misaligned word load
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h3001, 32'h0);
    #1 chk("mis_stall", {31'b0, stall_o}, 32'h0);
    cyc();
    valid_i = 1'b0;
    chk("mis_req", {31'b0, dmem_req_valid}, 32'h0);
    chk("mis_valid_o", {31'b0, valid_o}, 32'h1);
    chk("mis_flag", {31'b0, misalign_o}, 32'h1);
    chk("mis_wb", wb_data, 32'h3001);
    cyc();
    chk("mis_clear", {31'b0, misalign_o}, 32'h0);

    // Async reset while in WAIT
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h5000, 32'h0);
    cyc();
    valid_i = 1'b0; dmem_req_ready = 1'b1;
    cyc();
    dmem_req_ready = 1'b0;
    chk("rw_pre_stall", {31'b0, stall_o}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rw_req", {31'b0, dmem_req_valid}, 32'h0);
    chk("rw_valid_o", {31'b0, valid_o}, 32'h0);
    chk("rw_stall", {31'b0, stall_o}, 32'h0);
    reset = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h55555555;
    cyc();
    dmem_rsp_valid = 1'b0;
    chk("rw_stray_valid_o", {31'b0, valid_o}, 32'h0);

    // Load followed by an ALU op held upstream by the stall
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h600, 32'h6000, 32'h0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h604, 32'h77, 32'h0);
    dmem_req_ready = 1'b1;
    #1 chk("b2b_req_stall", {31'b0, stall_o}, 32'h1);
    cyc();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    #1 chk("b2b_rsp_stall", {31'b0, stall_o}, 32'h1);
    cyc();
    dmem_rsp_valid = 1'b0;
    chk("b2b_ld_valid", {31'b0, valid_o}, 32'h1);
    chk("b2b_ld_wb", wb_data, 32'hCAFEF00D);
    chk("b2b_ld_pc", pc_o, 32'h600);
    chk("b2b_alu_unstalled", {31'b0, stall_o}, 32'h0);
    cyc();
    valid_i = 1'b0;
    chk("b2b_alu_valid", {31'b0, valid_o}, 32'h1);
    chk("b2b_alu_pc", pc_o, 32'h604);
    chk("b2b_alu_wb", wb_data, 32'h77);
    cyc();
    chk("b2b_no_dup", {31'b0, valid_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
